// File: rtl/alu_cmd_ctrl_if.sv
// Command byte link, ALU operand/result bus and status flags.
// master drives command/result inputs, slave is the controller.
interface alu_cmd_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_fun;
  logic [15:0] alu_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        err;

  modport master (
    output rx_data, rx_valid, alu_out, tx_ready,
    input  rx_ready, alu_a, alu_b, alu_fun,
    input  tx_data, tx_valid, busy, err
  );

  modport slave (
    input  rx_data, rx_valid, alu_out, tx_ready,
    output rx_ready, alu_a, alu_b, alu_fun,
    output tx_data, tx_valid, busy, err
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Collects a 5-byte command frame, drives an external ALU and
// returns its 16-bit result as two bytes, low byte first.
module alu_cmd_ctrl #(
  parameter int unsigned ALU_LAT = 1
) (
  input logic          CLK,
  input logic          RST,
  alu_cmd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    GET_A0,
    GET_A1,
    GET_B0,
    GET_B1,
    EXEC,
    SEND_LO,
    SEND_HI
  } state_t;

  localparam logic [3:0] LAST = 4'(ALU_LAT);

  state_t      state;
  logic [15:0] result;
  logic [3:0]  cnt;
  logic        rx_fire;
  logic        tx_fire;

  assign rx_fire = bus.rx_valid && bus.rx_ready;
  assign tx_fire = bus.tx_valid && bus.tx_ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      result       <= '0;
      cnt          <= '0;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_fun  <= '0;
      bus.tx_data  <= '0;
      bus.tx_valid <= 1'b0;
      bus.rx_ready <= 1'b1;
      bus.busy     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_fire) begin
            if (bus.rx_data[7:4] == 4'h0) begin
              bus.alu_fun <= bus.rx_data[3:0];
              bus.busy    <= 1'b1;
              state       <= GET_A0;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        GET_A0: begin
          if (rx_fire) begin
            bus.alu_a[7:0] <= bus.rx_data;
            state          <= GET_A1;
          end
        end
        GET_A1: begin
          if (rx_fire) begin
            bus.alu_a[15:8] <= bus.rx_data;
            state           <= GET_B0;
          end
        end
        GET_B0: begin
          if (rx_fire) begin
            bus.alu_b[7:0] <= bus.rx_data;
            state          <= GET_B1;
          end
        end
        GET_B1: begin
          if (rx_fire) begin
            bus.alu_b[15:8] <= bus.rx_data;
            bus.rx_ready    <= 1'b0;
            cnt             <= '0;
            state           <= EXEC;
          end
        end
        EXEC: begin
          // wait out the ALU pipeline plus its output register
          if (cnt == LAST) begin
            result       <= bus.alu_out;
            bus.tx_data  <= bus.alu_out[7:0];
            bus.tx_valid <= 1'b1;
            cnt          <= '0;
            state        <= SEND_LO;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SEND_LO: begin
          if (tx_fire) begin
            bus.tx_data <= result[15:8];
            state       <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (tx_fire) begin
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            bus.busy     <= 1'b0;
            bus.rx_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 Parameter ALU_LAT, default 1: clock edges from operand/opcode registration to a valid registered ALU_OUT; legal range 1..14.
REQ-002 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 RST  input  1  reset, asynchronous and active-low.
REQ-004 RX_DATA  input  8  command byte stream.
REQ-005 RX_VALID  input  1  RX_DATA valid; byte accepted on an edge where RX_VALID&&RX_READY.
REQ-006 RX_READY  output  1  block can accept a byte.
REQ-007 ALU_A, ALU_B  output  16 each  operands to the downstream ALU, registered.
REQ-008 ALU_FUN  output  4  opcode to the ALU, registered.
REQ-009 ALU_OUT  input  16  registered ALU result.
REQ-010 TX_DATA  output  8  result byte.
REQ-011 TX_VALID  output  1  TX_DATA valid; byte consumed on an edge where TX_VALID&&TX_READY.
REQ-012 TX_READY  input  1  sink can accept a byte.
REQ-013 BUSY  output  1  high in every state except IDLE.
REQ-014 ERR  output  1  one-cycle pulse on a rejected opcode byte.

Function
REQ-015 Frame SHALL be 5 bytes in order: OP, A[7:0], A[15:8], B[7:0], B[15:8].
REQ-016 FSM states SHALL be IDLE, GET_A0, GET_A1, GET_B0, GET_B1, EXEC, SEND_LO, SEND_HI.
REQ-017 RX_READY SHALL be 1 in IDLE, GET_A0, GET_A1, GET_B0 and GET_B1, and 0 in EXEC, SEND_LO and SEND_HI; RX_VALID while RX_READY=0 is ignored.
REQ-018 IDLE: an accepted byte with bits[7:4]=0 loads ALU_FUN<=byte[3:0] and moves to GET_A0; bits[7:4]!=0 discards the byte, pulses ERR next cycle and stays in IDLE.
REQ-019 Opcode 4'b1111 SHALL be accepted and forwarded unchanged; the result is whatever the ALU returns.
REQ-020 Each GET_* state SHALL load its byte into the matching ALU_A/ALU_B half on acceptance and advance; without a valid byte it holds indefinitely (no timeout).
REQ-021 Acceptance of the B[15:8] byte at edge k SHALL enter EXEC; ALU_A/ALU_B/ALU_FUN are final from edge k and held unchanged until the next frame's OP byte.
REQ-022 EXEC SHALL last exactly ALU_LAT+1 cycles (4-bit counter); at edge k+ALU_LAT+1 ALU_OUT is captured into a 16-bit result register and the FSM enters SEND_LO.
REQ-023 SEND_LO: TX_VALID=1, TX_DATA=result[7:0]; on handshake go to SEND_HI.
REQ-024 SEND_HI: TX_VALID=1, TX_DATA=result[15:8]; on handshake go to IDLE.
REQ-025 While TX_VALID=1 and TX_READY=0, TX_DATA SHALL hold stable; TX_VALID SHALL never drop without a handshake.
REQ-026 TX_VALID SHALL be 0 in all states other than SEND_LO and SEND_HI; TX_DATA is 0 whenever TX_VALID=0.
REQ-027 Minimum frame-to-frame period with TX_READY=1 SHALL be 5+(ALU_LAT+1)+2 cycles.

Reset
REQ-028 RST=0 SHALL immediately force IDLE, ALU_A=ALU_B=0, ALU_FUN=0, result=0, EXEC counter=0, TX_DATA=0, TX_VALID=0, BUSY=0, ERR=0; RX_READY=1 after release.
REQ-029 Reset mid-frame or mid-send SHALL discard all partial frame and result data; the first accepted byte after release is treated as OP.

Verification
REQ-030 OP=0x00, A=0x0003, B=0x0004, TX_READY=1 -> TX bytes 0x07 then 0x00; TX_VALID first high ALU_LAT+1 cycles after the last RX byte.
REQ-031 OP=0x01, A=0x0000, B=0x0001 -> TX 0xFF then 0xFF (16-bit wrap).
REQ-032 RX byte 0x23 in IDLE -> ERR high one cycle, no TX, BUSY stays 0; then OP=0x0B, A=0x0005, B=0x0002 -> TX 0x02, 0x00.
REQ-033 TX_READY held low 5 cycles in SEND_LO -> TX_VALID=1 and TX_DATA constant throughout; both bytes delivered in order once TX_READY=1.
REQ-034 RST asserted after 3 bytes accepted, then released -> all outputs at reset values; a full OP=0x04, A=0x00FF, B=0x0F0F frame -> TX 0x0F, 0x00.
REQ-035 RX_VALID held high with data during EXEC/SEND_* -> RX_READY=0, ALU_A/ALU_B/ALU_FUN unchanged, no bytes consumed.
